dht11_poll_scheduler: RTL and testbench

Sequencer for the DHT11 sensor interface. It periodically issues a start pulse to the DHT11 bus controller and waits for done, with a timeout. It then validates the checksum, retries on failure and latches the last good humidity/temperature bytes. Its outputs feed the FND display controller: rh_data/t_data plus an update strobe in place of dht11_done, and a valid/error status for the display.

---
 rtl/dht11_poll_scheduler_if.sv | 54 +++++
 rtl/dht11_poll_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_dht11_poll_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dht11_poll_scheduler_if.sv
// rtl/dht11_poll_scheduler_if.sv - handshake and data bundle between the DHT11 poll scheduler and its environment
//
// Purpose: groups the enable, bus-controller handshake, received frame bytes
//          and display-side outputs of dht11_poll_scheduler.
// Signals (direction given from the scheduler's point of view):
//   i_enable       polling enable level
//   i_dht11_done   1-cycle frame-received pulse from the bus controller
//   i_rh_int/i_rh_dec/i_t_int/i_t_dec/i_checksum  received frame bytes
//   o_dht11_start  1-cycle start pulse to the bus controller
//   o_rh_data/o_t_data  last good humidity / temperature integer bytes
//   o_data_update  1-cycle refresh strobe
//   o_data_valid   good read since last error or reset
//   o_error_flag   retries exhausted
//   o_busy         transaction in flight
//   o_err_count    failure counter (only with DHT11_ERR_CNT_EN defined)
// Modports: slave = scheduler, master = environment / bus-controller side.
// Optional feature macro: DHT11_ERR_CNT_EN
interface dht11_poll_scheduler_if;
  logic       i_enable;
  logic       i_dht11_done;
  logic [7:0] i_rh_int;
  logic [7:0] i_rh_dec;
  logic [7:0] i_t_int;
  logic [7:0] i_t_dec;
  logic [7:0] i_checksum;
  logic       o_dht11_start;
  logic [7:0] o_rh_data;
  logic [7:0] o_t_data;
  logic       o_data_update;
  logic       o_data_valid;
  logic       o_error_flag;
  logic       o_busy;
`ifdef DHT11_ERR_CNT_EN
  logic [7:0] o_err_count;
`endif

  modport slave (
    input  i_enable, i_dht11_done, i_rh_int, i_rh_dec, i_t_int, i_t_dec, i_checksum,
    output o_dht11_start, o_rh_data, o_t_data, o_data_update, o_data_valid,
`ifdef DHT11_ERR_CNT_EN
    output o_err_count,
`endif
    output o_error_flag, o_busy
  );

  modport master (
    output i_enable, i_dht11_done, i_rh_int, i_rh_dec, i_t_int, i_t_dec, i_checksum,
    input  o_dht11_start, o_rh_data, o_t_data, o_data_update, o_data_valid,
`ifdef DHT11_ERR_CNT_EN
    input  o_err_count,
`endif
    input  o_error_flag, o_busy
  );
endinterface

// File: rtl/dht11_poll_scheduler.sv
// rtl/dht11_poll_scheduler.sv - periodic DHT11 read sequencer with timeout, checksum check and retry
//
// Purpose: issues start pulses to the DHT11 bus controller, waits for the
//          frame with a timeout, validates the checksum, retries on failure
//          and latches the last good humidity/temperature bytes for display.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous, active-high reset
//   bus      dht11_poll_scheduler_if.slave (enable, handshake, frame bytes, status outputs)
// Optional feature macro: DHT11_ERR_CNT_EN (adds saturating failure counter o_err_count)
module dht11_poll_scheduler #(
  parameter int TICK_DIV       = 100000,
  parameter int POLL_PERIOD_MS = 2000,
  parameter int RETRY_MS       = 1000,
  parameter int TIMEOUT_MS     = 50,
  parameter int MAX_RETRY      = 3
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  dht11_poll_scheduler_if.slave  bus
);

  localparam int MS_MAX = (POLL_PERIOD_MS > RETRY_MS)
                        ? ((POLL_PERIOD_MS > TIMEOUT_MS) ? POLL_PERIOD_MS : TIMEOUT_MS)
                        : ((RETRY_MS > TIMEOUT_MS) ? RETRY_MS : TIMEOUT_MS);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

  localparam logic [PW-1:0] L_PRESC_LAST   = PW'(TICK_DIV - 1);
  localparam logic [MW-1:0] L_TIMEOUT_LAST = MW'(TIMEOUT_MS - 1);
  localparam logic [MW-1:0] L_POLL_LAST    = MW'(POLL_PERIOD_MS - 1);
  localparam logic [MW-1:0] L_RETRY_LAST   = MW'(RETRY_MS - 1);
  localparam logic [3:0]    L_MAX_RETRY    = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_CHECK,
    S_HOLDOFF
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [MW-1:0] r_ms_cnt;
  logic          r_hold_long;   // HOLDOFF length: 1 = poll period, 0 = retry gap
  logic [3:0]    r_retry;
  logic [7:0]    r_rh_int, r_rh_dec, r_t_int, r_t_dec, r_csum;

  logic          r_start;
  logic [7:0]    r_rh_data;
  logic [7:0]    r_t_data;
  logic          r_update;
  logic          r_valid;
  logic          r_error;
  logic          r_busy;

  logic          w_tick;
  logic          w_timeout;
  logic          w_hold_done;
  logic [MW-1:0] w_hold_last;
  logic [7:0]    w_sum;
  logic          w_fail;

  // The last cycle of an N-ms window is the one where both counters sit on
  // their final value, so a window lasts exactly N*TICK_DIV cycles.
  assign w_tick      = (r_presc == L_PRESC_LAST);
  assign w_timeout   = w_tick && (r_ms_cnt == L_TIMEOUT_LAST);
  assign w_hold_last = r_hold_long ? L_POLL_LAST : L_RETRY_LAST;
  assign w_hold_done = w_tick && (r_ms_cnt == w_hold_last);
  assign w_sum       = r_rh_int + r_rh_dec + r_t_int + r_t_dec;

  // A done pulse in the timeout cycle takes precedence over the timeout.
  assign w_fail = ((r_state == S_WAIT_DONE) && !bus.i_dht11_done && w_timeout) ||
                  ((r_state == S_CHECK) && (w_sum != r_csum));

`ifdef DHT11_ERR_CNT_EN
  logic [7:0] r_err_count;
  assign bus.o_err_count = r_err_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err_count <= 8'd0;
    end else if (w_fail && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_ms_cnt    <= '0;
      r_hold_long <= 1'b0;
      r_retry     <= 4'd0;
      r_rh_int    <= 8'd0;
      r_rh_dec    <= 8'd0;
      r_t_int     <= 8'd0;
      r_t_dec     <= 8'd0;
      r_csum      <= 8'd0;
      r_start     <= 1'b0;
      r_rh_data   <= 8'd0;
      r_t_data    <= 8'd0;
      r_update    <= 1'b0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_start  <= 1'b0;
      r_update <= 1'b0;

      // Timebase only runs in the timed states, so it never wraps mid-window.
      if ((r_state == S_WAIT_DONE) || (r_state == S_HOLDOFF)) begin
        if (w_tick) begin
          r_presc  <= '0;
          r_ms_cnt <= r_ms_cnt + MW'(1);
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end

      if (w_fail) begin
        r_state  <= S_HOLDOFF;
        r_busy   <= 1'b0;
        r_presc  <= '0;
        r_ms_cnt <= '0;
        if (r_retry < L_MAX_RETRY) begin
          r_retry     <= r_retry + 4'd1;
          r_hold_long <= 1'b0;
        end else begin
          r_retry     <= 4'd0;
          r_error     <= 1'b1;
          r_valid     <= 1'b0;
          r_hold_long <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.i_enable) begin
              r_state <= S_START;
              r_start <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          S_START: begin
            r_state  <= S_WAIT_DONE;
            r_presc  <= '0;
            r_ms_cnt <= '0;
          end
          S_WAIT_DONE: begin
            if (bus.i_dht11_done) begin
              r_rh_int <= bus.i_rh_int;
              r_rh_dec <= bus.i_rh_dec;
              r_t_int  <= bus.i_t_int;
              r_t_dec  <= bus.i_t_dec;
              r_csum   <= bus.i_checksum;
              r_state  <= S_CHECK;
            end
          end
          S_CHECK: begin
            // Only reached here on a checksum match; mismatch is w_fail.
            r_rh_data   <= r_rh_int;
            r_t_data    <= r_t_int;
            r_update    <= 1'b1;
            r_valid     <= 1'b1;
            r_error     <= 1'b0;
            r_retry     <= 4'd0;
            r_hold_long <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_HOLDOFF;
            r_presc     <= '0;
            r_ms_cnt    <= '0;
          end
          S_HOLDOFF: begin
            if (w_hold_done) begin
              if (bus.i_enable) begin
                r_state <= S_START;
                r_start <= 1'b1;
                r_busy  <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_dht11_start = r_start;
  assign bus.o_rh_data     = r_rh_data;
  assign bus.o_t_data      = r_t_data;
  assign bus.o_data_update = r_update;
  assign bus.o_data_valid  = r_valid;
  assign bus.o_error_flag  = r_error;
  assign bus.o_busy        = r_busy;

endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// tb/tb_dht11_poll_scheduler.sv - self-checking bench for dht11_poll_scheduler
module tb_dht11_poll_scheduler;
  localparam int TICK  = 10;
  localparam int POLL  = 20;
  localparam int RETRY = 10;
  localparam int TMO   = 5;
  localparam int MAXR  = 2;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_start = 0;

  // Transaction-level reference state
  int         m_retry = 0;
  int         m_errcnt = 0;
  int         m_valid = 0;
  int         m_error = 0;
  logic [7:0] m_rh = 8'd0;
  logic [7:0] m_t = 8'd0;

  dht11_poll_scheduler_if bus();

  dht11_poll_scheduler #(
    .TICK_DIV(TICK), .POLL_PERIOD_MS(POLL), .RETRY_MS(RETRY),
    .TIMEOUT_MS(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .bus(bus)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_good(input logic [7:0] rh, input logic [7:0] t, output int wait_c);
    m_retry = 0; m_valid = 1; m_error = 0; m_rh = rh; m_t = t;
    wait_c = POLL * TICK;
  endtask

  task automatic model_fail(output int wait_c);
    if (m_errcnt < 255) m_errcnt++;
    if (m_retry < MAXR) begin
      m_retry++;
      wait_c = RETRY * TICK;
    end else begin
      m_retry = 0; m_error = 1; m_valid = 0;
      wait_c = POLL * TICK;
    end
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_rh"},    int'(bus.o_rh_data), int'(m_rh));
    check_eq({tag, "_t"},     int'(bus.o_t_data), int'(m_t));
    check_eq({tag, "_valid"}, int'(bus.o_data_valid), m_valid);
    check_eq({tag, "_error"}, int'(bus.o_error_flag), m_error);
`ifdef DHT11_ERR_CNT_EN
    check_eq({tag, "_errcnt"}, int'(bus.o_err_count), m_errcnt);
`endif
  endtask

  task automatic wait_start(output int t);
    int n = 0;
    while (!bus.o_dht11_start && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    check_eq("start_seen", int'(bus.o_dht11_start), 1);
    t = cyc;
  endtask

  // d = cycles from the start cycle to the done pulse (1..TMO*TICK), 0 = never answer
  task automatic run_txn(input int d, input logic [7:0] rh_i, input logic [7:0] rh_d,
                         input logic [7:0] t_i, input logic [7:0] t_d,
                         input logic [7:0] cs, input bit drop_en);
    int t, wait_c;
    logic [7:0] sum;
    wait_start(t);
    check_eq("start_cycle", t, exp_start);
    check_eq("busy_start", int'(bus.o_busy), 1);
    @(negedge i_clk);
    check_eq("start_width", int'(bus.o_dht11_start), 0);
    check_eq("busy_wait", int'(bus.o_busy), 1);
    if (drop_en) bus.i_enable = 1'b0;
    if (d > 0) begin
      repeat (d - 1) @(negedge i_clk);
      bus.i_rh_int = rh_i; bus.i_rh_dec = rh_d; bus.i_t_int = t_i; bus.i_t_dec = t_d;
      bus.i_checksum = cs;
      bus.i_dht11_done = 1'b1;
      @(negedge i_clk);
      bus.i_dht11_done = 1'b0;
      check_eq("busy_check", int'(bus.o_busy), 1);
      check_eq("update_early", int'(bus.o_data_update), 0);
      @(negedge i_clk);
      sum = rh_i + rh_d + t_i + t_d;
      if (sum == cs) begin
        model_good(rh_i, t_i, wait_c);
        check_eq("update_good", int'(bus.o_data_update), 1);
      end else begin
        model_fail(wait_c);
        check_eq("update_bad", int'(bus.o_data_update), 0);
      end
      check_eq("busy_hold", int'(bus.o_busy), 0);
      check_status("after_check");
      exp_start = t + d + 2 + wait_c;
      // A stray done during HOLDOFF must be ignored.
      @(negedge i_clk);
      check_eq("update_width", int'(bus.o_data_update), 0);
      bus.i_rh_int = 8'($urandom); bus.i_t_int = 8'($urandom);
      bus.i_rh_dec = 8'd0; bus.i_t_dec = 8'd0;
      bus.i_checksum = bus.i_rh_int + bus.i_t_int;
      bus.i_dht11_done = 1'b1;
      @(negedge i_clk);
      bus.i_dht11_done = 1'b0;
      @(negedge i_clk);
      check_eq("stray_busy", int'(bus.o_busy), 0);
      check_eq("stray_update", int'(bus.o_data_update), 0);
      check_status("stray");
    end else begin
      repeat (TMO * TICK - 1) @(negedge i_clk);
      check_eq("busy_last_wait", int'(bus.o_busy), 1);
      @(negedge i_clk);
      model_fail(wait_c);
      check_eq("busy_timeout", int'(bus.o_busy), 0);
      check_eq("update_timeout", int'(bus.o_data_update), 0);
      check_status("timeout");
      exp_start = t + TMO * TICK + 1 + wait_c;
    end
  endtask

  task automatic random_txn(input int d, input bit good);
    logic [7:0] a, b, c, e, cs;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); e = 8'($urandom);
    cs = a + b + c + e;
    if (!good) cs = cs + 8'($urandom_range(1, 255));
    run_txn(d, a, b, c, e, cs, 1'b0);
  endtask

  initial begin
    int starts;
    bus.i_enable = 1'b1; bus.i_dht11_done = 1'b0;
    bus.i_rh_int = 8'd0; bus.i_rh_dec = 8'd0; bus.i_t_int = 8'd0; bus.i_t_dec = 8'd0;
    bus.i_checksum = 8'd0;
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    check_eq("rst_start", int'(bus.o_dht11_start), 0);
    check_eq("rst_update", int'(bus.o_data_update), 0);
    check_eq("rst_busy", int'(bus.o_busy), 0);
    check_status("rst");
    i_reset = 1'b0;
    exp_start = cyc + 1;

    // Good read, then checksum error, then timeouts to exhaustion, then recovery
    run_txn(8, 8'd45, 8'd0, 8'd23, 8'd0, 8'd68, 1'b0);
    check_eq("good_rh45", int'(bus.o_rh_data), 45);
    check_eq("good_t23", int'(bus.o_t_data), 23);
    run_txn(8, 8'd45, 8'd0, 8'd23, 8'd0, 8'd69, 1'b0);
    run_txn(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    run_txn(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    check_eq("exhaust_error", int'(bus.o_error_flag), 1);
    check_eq("exhaust_valid", int'(bus.o_data_valid), 0);
    run_txn(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    run_txn(12, 8'd50, 8'd1, 8'd20, 8'd2, 8'd73, 1'b0);
    check_eq("recover_error", int'(bus.o_error_flag), 0);
    check_eq("recover_valid", int'(bus.o_data_valid), 1);

    // Done in the exact timeout cycle wins; also after a prior failure
    random_txn(1, 1'b0);
    random_txn(TMO * TICK, 1'b1);
    random_txn(TMO * TICK, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) random_txn(0, 1'b0);
      else random_txn($urandom_range(1, TMO * TICK), 1'($urandom_range(0, 1)));
    end

    // Enable dropped mid-transaction: completes, then idles with no starts
    run_txn(8, 8'd45, 8'd0, 8'd23, 8'd0, 8'd68, 1'b1);
    starts = 0;
    while (cyc < exp_start + 30) begin
      @(negedge i_clk);
      if (bus.o_dht11_start) starts++;
    end
    check_eq("disabled_starts", starts, 0);
    check_eq("disabled_busy", int'(bus.o_busy), 0);
    bus.i_enable = 1'b1;
    exp_start = cyc + 1;
    random_txn(20, 1'b1);

    // Reset while in HOLDOFF
    random_txn(5, 1'b1);
    i_reset = 1'b1;
    @(negedge i_clk);
    m_retry = 0; m_valid = 0; m_error = 0; m_rh = 8'd0; m_t = 8'd0; m_errcnt = 0;
    check_eq("midrst_start", int'(bus.o_dht11_start), 0);
    check_eq("midrst_update", int'(bus.o_data_update), 0);
    check_eq("midrst_busy", int'(bus.o_busy), 0);
    check_status("midrst");
    i_reset = 1'b0;
    exp_start = cyc + 1;
    for (int i = 0; i < 3; i++) random_txn(0, 1'b0);
`ifdef DHT11_ERR_CNT_EN
    check_eq("errcnt_3", int'(bus.o_err_count), 3);
    for (int i = 0; i < 300; i++) random_txn(1, 1'b0);
    check_eq("errcnt_sat", int'(bus.o_err_count), 255);
`endif
    random_txn(7, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #(99000 * 10);
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1);
  end
endmodule
